imem_prog_ctrl: RTL and testbench
=================================

# imem_prog_ctrl

Sequencing controller that reloads the byte-addressed instruction memory from an external byte stream (debug/UART side) while holding the single-cycle core off the fetch path. It owns the instruction memory's byte write port, stalls the core for the duration of a load, enforces length and inactivity-timeout rules, and issues a one-cycle core reset when a new image is in place. It sits between the programming link, the instruction memory's write side and the core's stall/reset inputs.

## Interface
- MEM_BYTES, 128: instruction memory size in bytes.
- ADDR_W, 7: byte address width, equal to $clog2(MEM_BYTES).
- TIMEOUT, 16: consecutive LOAD cycles without a byte handshake before the load is aborted.

- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Prog_Start  in  1  single-cycle request to begin a load.
- Prog_Len  in  8  number of bytes to load; sampled when Prog_Start is accepted.
- Byte_Valid  in  1  stream byte present.
- Byte_Data  in  8  stream byte.
- Byte_Ready  out  1  controller accepts a byte this cycle.
- Mem_WE  out  1  instruction memory byte write enable.
- Mem_WAddr  out  ADDR_W  instruction memory byte write address.
- Mem_WData  out  8  instruction memory write byte.
- Cpu_Stall  out  1  core holds PC and suppresses register/data writes.
- Cpu_Rst  out  1  one-cycle reset pulse to the core, which returns the PC to 0.
- Busy  out  1  load in progress.
- Done  out  1  one-cycle pulse on successful load completion.
- Err  out  1  error flag.

## Operation
- The states are IDLE, LOAD, RELEASE and ERROR. They are defined as an enum in the package.
- **IDLE.** The core runs normally. When Prog_Start=1:
  - If 1 ≤ Prog_Len ≤ MEM_BYTES, latch the length, clear the byte counter and the timeout counter, and go to LOAD.
  - Otherwise, pulse Err for one cycle and stay in IDLE.
- **LOAD.** Byte_Ready=1, Cpu_Stall=1, Busy=1.
  - Mem_WE = Byte_Valid & Byte_Ready. Mem_WAddr = the byte counter. Mem_WData = Byte_Data. These are combinational, so the write lands on the handshake edge.
  - On each handshake, the byte counter increments and the timeout counter clears.
  - On a handshake of byte number Prog_Len (counter == len-1), go to RELEASE.
  - On each cycle without a handshake, the timeout counter increments. When it reaches TIMEOUT, go to ERROR.
  - Prog_Start is ignored in LOAD.
- **RELEASE.** Lasts exactly one cycle: Cpu_Rst=1, Done=1, Cpu_Stall=1, Byte_Ready=0. Then go to IDLE.
- **ERROR.** Cpu_Stall=1 and Err=1 (level). Byte_Ready=0. The core stays stalled because the image is partial.
  - The only exit is a Prog_Start with a valid length, which goes to LOAD and restarts from address 0.
  - A Prog_Start with an invalid length keeps the controller in ERROR.
- **Arithmetic.**
  - The byte counter is ADDR_W+1 bits, so it never wraps within a legal length.
  - Mem_WAddr is the low ADDR_W bits of the byte counter.
  - Bytes are written little-endian in stream order, so byte 4k is the LSB of word k.
- **Reset.** RST in any state has priority over every other input.
  - State returns to IDLE and both counters clear.
  - Memory contents are not touched; a partially loaded image remains.

## Timing
- **Reset values:** Byte_Ready=0, Mem_WE=0, Mem_WAddr=0, Mem_WData=Byte_Data (pass-through), Cpu_Stall=0, Cpu_Rst=0, Busy=0, Done=0, Err=0.
- **Start latency:** if Prog_Start is accepted at edge t, LOAD begins in cycle t+1. A byte may be accepted in that same cycle.
- **Completion:** if the final byte is accepted at edge k, RELEASE occupies cycle k+1 and IDLE begins in cycle k+2, when Cpu_Stall drops.
- **Throughput:** one byte per cycle maximum.
- **Timeout:** ERROR is entered at the edge that ends the TIMEOUT-th consecutive handshake-free LOAD cycle.
- **Output decoding:** Cpu_Stall, Busy, Err and Done are decoded from registered state, so they are glitch-free. Mem_WE is the combinational handshake.

## Structure
- **Package `imem_pkg`:**
  - `imem_state_t` enum (IDLE, LOAD, RELEASE, ERROR).
  - Default localparams MEM_BYTES=128 and ADDR_W=7.
- **Sub-module `imem_timeout`:** a clearable saturating counter with an `expired` output, parameterized by TIMEOUT.
- **Remainder:** one FSM plus the byte counter in the top module.
- **Integration:** the instruction memory gains a byte write port (WE/WAddr/WData). Its read port is unchanged.

## Test plan
- **Full 8-byte load:**
  - Stimulus: Prog_Len=8, bytes 0x13,0x00,0x10,0x00,0x93,0x00,0x20,0x00 back-to-back.
  - Required response: 8 Mem_WE pulses at addresses 0–7, words 0x00100013 and 0x00200093 readable at 0 and 4, Done and Cpu_Rst each high for exactly 1 cycle, Cpu_Stall high from start+1 to last+1.
- **Gapped stream:**
  - Stimulus: Prog_Len=4, Byte_Valid toggled 1/0 with gaps of 15 cycles.
  - Required response: all 4 bytes written, no Err, Done pulses once.
- **Timeout:**
  - Stimulus: Prog_Len=4, 2 bytes then Byte_Valid=0 for 16 cycles.
  - Required response: ERROR entered, with Err=1, Cpu_Stall=1 and Byte_Ready=0.
  - Follow-up: a new Prog_Start with Prog_Len=4 restarts at Mem_WAddr=0.
- **Invalid length:**
  - Stimulus: Prog_Len=0, then Prog_Len=129.
  - Required response: a 1-cycle Err pulse each time, state stays IDLE, no Mem_WE.
- **Maximum length:**
  - Stimulus: Prog_Len=128.
  - Required response: the last write goes to address 127, then Done; no wrap to address 0.
- **Reset mid-load:**
  - Stimulus: RST asserted after 3 of 8 bytes, with Prog_Start=1 in the same cycle.
  - Required response: the next cycle is IDLE with every output at its reset value and Prog_Start ignored; bytes 0–2 remain in memory.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and defaults for the instruction-memory programming controller.
//   imem_state_t : controller FSM states (IDLE, LOAD, RELEASE, ERROR)
//   MEM_BYTES    : default instruction memory size in bytes
//   ADDR_W       : default byte address width, $clog2(MEM_BYTES)
//   LEN_W        : width of the requested load length
//   len_ok()     : true when a requested length fits in the memory (1..mem_bytes)
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int MEM_BYTES = 128;
  localparam int ADDR_W    = $clog2(MEM_BYTES);
  localparam int LEN_W     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    ERROR   = 2'd3
  } imem_state_t;

  // A zero-length image is meaningless and anything longer than the memory
  // would wrap onto already-written bytes, so both are rejected up front.
  function automatic logic len_ok(input logic [LEN_W-1:0] len, input int mem_bytes);
    return (len != '0) && (int'(len) <= mem_bytes);
  endfunction

endpackage : imem_pkg

// File: rtl/imem_prog_ctrl_timeout.sv
// -----------------------------------------------------------------------------
// imem_timeout
// Clearable saturating inactivity counter used while an image is streaming in.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   clr_i     : clear the count (has priority over inc_i)
//   inc_i     : count one idle cycle
//   expired_o : this idle cycle is the TIMEOUT-th consecutive one; the count
//               reaches TIMEOUT at the coming edge (or is already saturated)
// -----------------------------------------------------------------------------
module imem_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CW'(TIMEOUT))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag is combinational on the idle cycle itself so the owner can change
  // state at the same edge that ends the final permitted idle cycle.
  assign expired_o = inc_i && !clr_i && (count_d == CW'(TIMEOUT));

endmodule : imem_timeout

// File: rtl/imem_prog_ctrl.sv
// -----------------------------------------------------------------------------
// imem_prog_ctrl
// Reloads the byte-addressed instruction memory from an external byte stream
// while holding the core off the fetch path, then pulses a core reset.
// Ports:
//   CLK, RST             : clock and synchronous active-high reset
//   Prog_Start, Prog_Len : load request and its byte count (sampled on accept)
//   Byte_Valid/Data      : incoming stream byte
//   Byte_Ready           : controller accepts a byte this cycle (LOAD only)
//   Mem_WE/WAddr/WData   : instruction memory byte write port
//   Cpu_Stall            : core holds PC, suppresses writes (LOAD/RELEASE/ERROR)
//   Cpu_Rst              : one-cycle core reset after a completed load
//   Busy                 : load in progress
//   Done                 : one-cycle pulse on successful completion
//   Err                  : one-cycle pulse on a rejected length in IDLE,
//                          level while in ERROR
// -----------------------------------------------------------------------------
module imem_prog_ctrl #(
  parameter int MEM_BYTES = imem_pkg::MEM_BYTES,
  parameter int ADDR_W    = imem_pkg::ADDR_W,
  parameter int TIMEOUT   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Prog_Start,
  input  logic [7:0]        Prog_Len,
  input  logic              Byte_Valid,
  input  logic [7:0]        Byte_Data,
  output logic              Byte_Ready,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_WAddr,
  output logic [7:0]        Mem_WData,
  output logic              Cpu_Stall,
  output logic              Cpu_Rst,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  import imem_pkg::*;

  // One extra bit so a counter holding MEM_BYTES after the last byte never
  // aliases address 0.
  localparam int CNT_W = ADDR_W + 1;
  localparam int CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;

  imem_state_t      state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_pulse_q, err_pulse_d;

  logic handshake;
  logic last_byte;
  logic start_ok;
  logic to_clr;
  logic to_inc;
  logic to_expired;

  assign start_ok  = Prog_Start && len_ok(Prog_Len, MEM_BYTES);

  // Reset outranks a simultaneous byte: nothing is written on a reset edge.
  assign handshake = (state_q == LOAD) && Byte_Valid && !RST;

  // len_q is at least 1 whenever LOAD is active, so len-1 never underflows.
  assign last_byte = (CMP_W'(byte_cnt_q) == (CMP_W'(len_q) - CMP_W'(1)));

  // The inactivity counter only runs inside LOAD and restarts on every byte.
  assign to_clr = (state_q != LOAD) || handshake;
  assign to_inc = (state_q == LOAD) && !handshake;

  imem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (to_clr),
    .inc_i     (to_inc),
    .expired_o (to_expired)
  );

  // Write port: address straight from the counter so the byte lands on the
  // handshake edge; data is a pass-through of the stream.
  assign Mem_WE    = handshake;
  assign Mem_WAddr = byte_cnt_q[ADDR_W-1:0];
  assign Mem_WData = Byte_Data;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    err_pulse_d = 1'b0;

    Byte_Ready  = 1'b0;
    Cpu_Stall   = 1'b0;
    Cpu_Rst     = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    Err         = err_pulse_q;

    unique case (state_q)
      IDLE: begin
        if (Prog_Start) begin
          if (start_ok) begin
            len_d      = Prog_Len;
            byte_cnt_d = '0;
            state_d    = LOAD;
          end else begin
            err_pulse_d = 1'b1;
          end
        end
      end

      LOAD: begin
        Byte_Ready = 1'b1;
        Cpu_Stall  = 1'b1;
        Busy       = 1'b1;
        if (handshake) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (last_byte) begin
            state_d = RELEASE;
          end
        end else if (to_expired) begin
          state_d = ERROR;
        end
      end

      RELEASE: begin
        Cpu_Stall = 1'b1;
        Cpu_Rst   = 1'b1;
        Done      = 1'b1;
        state_d   = IDLE;
      end

      ERROR: begin
        // The image is partial, so the core stays stalled until a fresh,
        // valid load replaces it from address 0.
        Cpu_Stall = 1'b1;
        Err       = 1'b1;
        if (start_ok) begin
          len_d      = Prog_Len;
          byte_cnt_d = '0;
          state_d    = LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      err_pulse_q <= err_pulse_d;
    end
  end

endmodule : imem_prog_ctrl

// File: tb/tb_imem_prog_ctrl.sv
module tb_imem_prog_ctrl;

  localparam int MEM_BYTES = 128;
  localparam int ADDR_W    = 7;
  localparam int TIMEOUT   = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic              Prog_Start;
  logic [7:0]        Prog_Len;
  logic              Byte_Valid;
  logic [7:0]        Byte_Data;
  logic              Byte_Ready;
  logic              Mem_WE;
  logic [ADDR_W-1:0] Mem_WAddr;
  logic [7:0]        Mem_WData;
  logic              Cpu_Stall;
  logic              Cpu_Rst;
  logic              Busy;
  logic              Done;
  logic              Err;

  always #5 CLK = ~CLK;

  imem_prog_ctrl #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Prog_Start (Prog_Start),
    .Prog_Len   (Prog_Len),
    .Byte_Valid (Byte_Valid),
    .Byte_Data  (Byte_Data),
    .Byte_Ready (Byte_Ready),
    .Mem_WE     (Mem_WE),
    .Mem_WAddr  (Mem_WAddr),
    .Mem_WData  (Mem_WData),
    .Cpu_Stall  (Cpu_Stall),
    .Cpu_Rst    (Cpu_Rst),
    .Busy       (Busy),
    .Done       (Done),
    .Err        (Err)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural reference: what the controller is doing, in terms of the
  // load rules (loading / releasing / broken image / length-reject pulse).
  bit m_loading, m_release, m_error, m_errpulse;
  int m_len, m_count, m_idle;

  logic [7:0] imem      [MEM_BYTES];  // instruction memory fed by the DUT port
  logic [7:0] exp_image [MEM_BYTES];  // image the stream should have produced

  int n_we, n_done, n_cpurst, n_err, n_stall, first_waddr, last_waddr;
  logic s_ready, s_stall, s_busy, s_err;

  task automatic clr_stats();
    n_we = 0; n_done = 0; n_cpurst = 0; n_err = 0; n_stall = 0;
    first_waddr = -1; last_waddr = -1;
  endtask

  function automatic int image_diffs(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (imem[i] !== exp_image[i]) bad++;
    return bad;
  endfunction

  // One clock cycle: compare all outputs at the falling edge, then apply the
  // rising edge to the memory and the reference.
  task automatic step();
    logic [22:0] exp_v, got_v;
    bit          exp_we, ep, we_s;
    logic [6:0]  wa_s;
    logic [7:0]  wd_s;
    @(negedge CLK);
    exp_we = m_loading && Byte_Valid && !RST;
    exp_v  = {m_loading, exp_we, 7'(m_count), Byte_Data,
              (m_loading | m_release | m_error), m_release, m_loading,
              m_release, (m_error | m_errpulse)};
    got_v  = {Byte_Ready, Mem_WE, Mem_WAddr, Mem_WData, Cpu_Stall, Cpu_Rst,
              Busy, Done, Err};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, got_v, exp_v);
    end
    if (Mem_WE === 1'b1) begin
      n_we++;
      if (first_waddr < 0) first_waddr = int'(Mem_WAddr);
      last_waddr = int'(Mem_WAddr);
    end
    if (Done === 1'b1) n_done++;
    if (Cpu_Rst === 1'b1) n_cpurst++;
    if (Err === 1'b1) n_err++;
    if (Cpu_Stall === 1'b1) n_stall++;
    s_ready = Byte_Ready; s_stall = Cpu_Stall; s_busy = Busy; s_err = Err;
    we_s = (Mem_WE === 1'b1); wa_s = Mem_WAddr; wd_s = Mem_WData;
    @(posedge CLK);
    if (we_s) imem[wa_s] = wd_s;
    if (RST) begin
      m_loading = 0; m_release = 0; m_error = 0; m_errpulse = 0;
      m_count = 0; m_idle = 0;
    end else begin
      ep = 0;
      if (m_release) begin
        m_release = 0;
      end else if (m_loading) begin
        if (Byte_Valid) begin
          exp_image[m_count] = Byte_Data;
          m_count++;
          m_idle = 0;
          if (m_count == m_len) begin m_loading = 0; m_release = 1; end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_loading = 0; m_error = 1; end
        end
      end else if (Prog_Start) begin
        if (Prog_Len >= 1 && int'(Prog_Len) <= MEM_BYTES) begin
          m_loading = 1; m_error = 0; m_len = int'(Prog_Len);
          m_count = 0; m_idle = 0;
        end else if (!m_error) begin
          ep = 1;
        end
      end
      m_errpulse = ep;
    end
    #1;
  endtask

  task automatic start_load(input int len);
    Prog_Start = 1'b1; Prog_Len = 8'(len); Byte_Valid = 1'b0;
    Byte_Data = 8'($urandom);
    step();
    Prog_Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    Byte_Valid = 1'b1; Byte_Data = b;
    step();
    Byte_Valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; Prog_Start = 1'b1; Prog_Len = 8'd4;
    Byte_Valid = 1'b1; Byte_Data = 8'h5a;
    @(posedge CLK); #1;
    clr_stats();
    repeat (2) step();
    RST = 1'b0; Prog_Start = 1'b0; Byte_Valid = 1'b0;
    step();
    checks++;
    if ({s_ready, s_stall, s_busy, s_err} !== 4'b0000 || n_we != 0) begin
      failures++;
      $display("FAIL reset_state got=%b we=%0d required=0000 we=0",
               {s_ready, s_stall, s_busy, s_err}, n_we);
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_full_load();
    logic [7:0] b [8];
    logic [31:0] w0, w1;
    b = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    clr_stats();
    start_load(8);
    for (int i = 0; i < 8; i++) send_byte(b[i]);
    step(); step();
    w0 = {imem[3], imem[2], imem[1], imem[0]};
    w1 = {imem[7], imem[6], imem[5], imem[4]};
    checks++;
    if (n_we != 8 || first_waddr != 0 || last_waddr != 7) begin
      failures++;
      $display("FAIL full_writes got n=%0d first=%0d last=%0d required 8/0/7",
               n_we, first_waddr, last_waddr);
    end
    checks++;
    if (w0 !== 32'h00100013 || w1 !== 32'h00200093) begin
      failures++;
      $display("FAIL full_words got %h %h required 00100013 00200093", w0, w1);
    end
    checks++;
    if (n_done != 1 || n_cpurst != 1 || n_stall != 9 || s_stall !== 1'b0) begin
      failures++;
      $display("FAIL full_pulses got done=%0d rst=%0d stall=%0d required 1/1/9",
               n_done, n_cpurst, n_stall);
    end
    $display("load len=8 writes=%0d done=%0d word0=%h word1=%h", n_we, n_done, w0, w1);
  endtask

  task automatic test_gapped();
    clr_stats();
    start_load(4);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom));
      repeat (15) step();
    end
    checks++;
    if (n_we != 4 || n_err != 0 || n_done != 1 || image_diffs(4) != 0) begin
      failures++;
      $display("FAIL gapped got we=%0d err=%0d done=%0d diffs=%0d required 4/0/1/0",
               n_we, n_err, n_done, image_diffs(4));
    end
    $display("load len=4 gapped writes=%0d done=%0d err=%0d", n_we, n_done, n_err);
  endtask

  task automatic test_timeout();
    clr_stats();
    start_load(4);
    send_byte(8'($urandom)); send_byte(8'($urandom));
    repeat (TIMEOUT) step();
    step();
    checks++;
    if ({s_err, s_stall, s_ready} !== 3'b110 || n_done != 0) begin
      failures++;
      $display("FAIL timeout_error got err/stall/ready=%b done=%0d required 110 done=0",
               {s_err, s_stall, s_ready}, n_done);
    end
    clr_stats();
    start_load(4);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    step(); step();
    checks++;
    if (first_waddr != 0 || n_we != 4 || n_done != 1 || s_err !== 1'b0
        || image_diffs(4) != 0) begin
      failures++;
      $display("FAIL timeout_restart got first=%0d we=%0d done=%0d err=%b required 0/4/1/0",
               first_waddr, n_we, n_done, s_err);
    end
    $display("load len=4 timeout then restart writes=%0d done=%0d", n_we, n_done);
  endtask

  task automatic test_invalid_len();
    int lens [2];
    lens = '{0, 129};
    foreach (lens[k]) begin
      clr_stats();
      Byte_Valid = 1'b1;
      Prog_Start = 1'b1; Prog_Len = 8'(lens[k]);
      step();
      Prog_Start = 1'b0;
      step(); step();
      Byte_Valid = 1'b0;
      checks++;
      if (n_err != 1 || n_we != 0 || n_stall != 0 || s_busy !== 1'b0) begin
        failures++;
        $display("FAIL invalid_len len=%0d got err=%0d we=%0d stall=%0d required 1/0/0",
                 lens[k], n_err, n_we, n_stall);
      end
      $display("start len=%0d rejected err_cycles=%0d", lens[k], n_err);
    end
  endtask

  task automatic test_max_len();
    int cyc = 0;
    clr_stats();
    start_load(MEM_BYTES);
    while (m_loading && cyc < 1000) begin
      Byte_Valid = ($urandom_range(3) != 0);
      Byte_Data  = 8'($urandom);
      step();
      cyc++;
    end
    Byte_Valid = 1'b0;
    checks++;
    if (m_loading) begin
      failures++;
      $display("FAIL max_len_budget got still_loading=1 required 0");
    end
    step(); step();
    checks++;
    if (last_waddr != 127 || n_we != 128 || n_done != 1
        || image_diffs(MEM_BYTES) != 0) begin
      failures++;
      $display("FAIL max_len got last=%0d we=%0d done=%0d diffs=%0d required 127/128/1/0",
               last_waddr, n_we, n_done, image_diffs(MEM_BYTES));
    end
    $display("load len=128 writes=%0d last_addr=%0d done=%0d", n_we, last_waddr, n_done);
  endtask

  task automatic test_reset_mid_load();
    clr_stats();
    start_load(8);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    RST = 1'b1; Prog_Start = 1'b1; Prog_Len = 8'd8;
    Byte_Valid = 1'b1; Byte_Data = 8'($urandom);
    step();
    RST = 1'b0; Prog_Start = 1'b0; Byte_Valid = 1'b0;
    step();
    checks++;
    if ({s_ready, s_stall, s_busy, s_err} !== 4'b0000 || n_we != 3
        || image_diffs(8) != 0) begin
      failures++;
      $display("FAIL reset_mid got rdy/stall/busy/err=%b we=%0d diffs=%0d required 0000/3/0",
               {s_ready, s_stall, s_busy, s_err}, n_we, image_diffs(8));
    end
    $display("load len=8 reset after 3 writes=%0d", n_we);
  endtask

  task automatic test_random_loads();
    for (int t = 0; t < 8; t++) begin
      int len, cyc, pct;
      len = ($urandom_range(4) == 0) ? (($urandom_range(1) == 0) ? 0 : 129 + $urandom_range(126))
                                     : 1 + $urandom_range(47);
      pct = (t % 4 == 3) ? 8 : 50 + $urandom_range(45);
      clr_stats();
      start_load(len);
      cyc = 0;
      while ((m_loading || m_release) && cyc < 2000) begin
        Byte_Valid = ($urandom_range(99) < pct);
        Byte_Data  = 8'($urandom);
        Prog_Start = ($urandom_range(7) == 0);
        Prog_Len   = 8'($urandom_range(1, 20));
        step();
        cyc++;
      end
      Byte_Valid = 1'b0; Prog_Start = 1'b0;
      step();
      checks++;
      if (cyc >= 2000 || image_diffs(MEM_BYTES) != 0) begin
        failures++;
        $display("FAIL random_load len=%0d got cycles=%0d diffs=%0d required <2000/0",
                 len, cyc, image_diffs(MEM_BYTES));
      end
      $display("random load len=%0d writes=%0d done=%0d err_cycles=%0d",
               len, n_we, n_done, n_err);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      imem[i] = 8'h00; exp_image[i] = 8'h00;
    end
    m_loading = 0; m_release = 0; m_error = 0; m_errpulse = 0;
    m_len = 0; m_count = 0; m_idle = 0;
    RST = 1'b1; Prog_Start = 1'b0; Prog_Len = 8'd0;
    Byte_Valid = 1'b0; Byte_Data = 8'd0;
    clr_stats();
    #1;
    test_reset();
    test_full_load();
    test_gapped();
    test_timeout();
    test_invalid_len();
    test_max_len();
    test_reset_mid_load();
    test_random_loads();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_imem_prog_ctrl
